// File: rtl/j1_encoder.sv
// J1 instruction encoder: turns LIT/branch/CALL/ALU requests into 16-bit J1 words with program addresses.
// Optional two-word literal expansion is enabled by defining J1_ENCODER_LONGLIT_EN.
module j1_encoder #(
    parameter bit STRICT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [15:0] req_value,
    input  logic [12:0] req_alu,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [12:0] instr_addr,
    input  logic        base_we,
    input  logic [12:0] base_addr,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1
`ifdef J1_ENCODER_LONGLIT_EN
        , LONG1 = 2'd2
`endif
    } state_t;

    localparam logic [15:0] INV_T_WORD = 16'h6600;

    state_t      state_r;
    logic [12:0] addr_r;
    logic        accept_s;
    logic [15:0] enc_word_s;
    logic [1:0]  enc_code_s;
`ifdef J1_ENCODER_LONGLIT_EN
    logic        enc_long_s;
`endif

    // Request can be taken when nothing is held, or the held word leaves this cycle.
    always_comb begin
        req_ready = 1'b0;
        if (reset) begin
            req_ready = 1'b0;
        end else if (state_r == IDLE) begin
            req_ready = 1'b1;
        end else if (state_r == EMIT) begin
            req_ready = instr_ready;
        end else begin
            req_ready = 1'b0;
        end
    end

    assign accept_s = req_valid & req_ready;

    // Encode the incoming request; enc_code_s != 0 marks a rejected request.
    always_comb begin
        enc_word_s = 16'h0000;
        enc_code_s = 2'd0;
`ifdef J1_ENCODER_LONGLIT_EN
        enc_long_s = 1'b0;
`endif
        case (req_kind)
            3'd0: begin
                if (req_value[15]) begin
`ifdef J1_ENCODER_LONGLIT_EN
                    enc_word_s = {1'b1, ~req_value[14:0]};
                    enc_long_s = 1'b1;
`else
                    enc_code_s = 2'd3;
`endif
                end else begin
                    enc_word_s = {1'b1, req_value[14:0]};
                end
            end
            3'd1, 3'd2, 3'd3: begin
                // Branch tags 000/001/010 are simply kind minus one.
                if (req_value[15:13] != 3'b000) begin
                    enc_code_s = 2'd1;
                end else begin
                    enc_word_s = {req_kind - 3'd1, req_value[12:0]};
                end
            end
            3'd4: begin
                if (STRICT && req_alu[4]) begin
                    enc_code_s = 2'd2;
                end else begin
                    enc_word_s = {3'b011, req_alu};
                end
            end
            default: begin
                enc_code_s = 2'd2;
            end
        endcase
    end

    // Output word, address counter and error pulse state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= 13'd0;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_addr  <= 13'd0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            err <= 1'b0;
            if (accept_s) begin
                if (enc_code_s != 2'd0) begin
                    err         <= 1'b1;
                    err_code    <= enc_code_s;
                    instr_valid <= 1'b0;
                    state_r     <= IDLE;
                end else begin
                    instr       <= enc_word_s;
                    instr_addr  <= addr_r;
                    addr_r      <= addr_r + 13'd1;
                    instr_valid <= 1'b1;
`ifdef J1_ENCODER_LONGLIT_EN
                    state_r     <= enc_long_s ? LONG1 : EMIT;
`else
                    state_r     <= EMIT;
`endif
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (base_we && !instr_valid) begin
                            addr_r <= base_addr;
                        end
                    end
                    EMIT: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
`ifdef J1_ENCODER_LONGLIT_EN
                    LONG1: begin
                        // Second word of a long literal inverts T to restore bit 15.
                        if (instr_ready) begin
                            instr      <= INV_T_WORD;
                            instr_addr <= addr_r;
                            addr_r     <= addr_r + 13'd1;
                            state_r    <= EMIT;
                        end
                    end
`endif
                    default: begin
                        instr_valid <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_j1_encoder.sv
// Directed scoreboard bench for j1_encoder; honours J1_ENCODER_LONGLIT_EN when defined.
module tb_j1_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [15:0] req_value;
    logic [12:0] req_alu;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [12:0] instr_addr;
    logic        base_we;
    logic [12:0] base_addr;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [28:0] exp_q[$];
    logic [1:0]  err_q[$];
    logic [12:0] exp_addr;
    logic [1:0]  last_code;

    j1_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_value  (req_value),
        .req_alu    (req_alu),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_addr (instr_addr),
        .base_we    (base_we),
        .base_addr  (base_addr),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back({w, exp_addr});
        exp_addr = exp_addr + 13'd1;
    endtask

    task automatic push_err(input logic [1:0] c);
        err_q.push_back(c);
        last_code = c;
    endtask

    // Reference model of the encoding and rejection rules.
    task automatic model(input logic [2:0] k, input logic [15:0] v, input logic [12:0] a);
        case (k)
            3'd0: begin
                if (v[15]) begin
`ifdef J1_ENCODER_LONGLIT_EN
                    push_word({1'b1, ~v[14:0]});
                    push_word(16'h6600);
`else
                    push_err(2'd3);
`endif
                end else begin
                    push_word({1'b1, v[14:0]});
                end
            end
            3'd1: if (v[15:13] != 3'd0) push_err(2'd1); else push_word({3'b000, v[12:0]});
            3'd2: if (v[15:13] != 3'd0) push_err(2'd1); else push_word({3'b001, v[12:0]});
            3'd3: if (v[15:13] != 3'd0) push_err(2'd1); else push_word({3'b010, v[12:0]});
            3'd4: if (a[4]) push_err(2'd2); else push_word({3'b011, a});
            default: push_err(2'd2);
        endcase
    endtask

    // Checks any output transfer or error pulse of this cycle, then advances one clock.
    task automatic tick();
        logic [28:0] e;
        logic [1:0]  c;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_word observed=%0h expected=none", instr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instr", {16'h0, instr}, {16'h0, e[28:13]});
                chk("instr_addr", {19'h0, instr_addr}, {19'h0, e[12:0]});
            end
        end
        if (err === 1'b1) begin
            n_cmp++;
            assert (err_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_err observed=%0h expected=none", err_code);
            end
            if (err_q.size() != 0) begin
                c = err_q.pop_front();
                chk("err_code", {30'h0, err_code}, {30'h0, c});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [15:0] v, input logic [12:0] a,
                        input bit use_model);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_kind  = k;
        req_value = v;
        req_alu   = a;
        for (int i = 0; i < 50 && !done; i++) begin
            if (req_ready === 1'b1) begin
                if (use_model) model(k, v, a);
                done = 1'b1;
            end
            tick();
        end
        chk("req_accepted", {31'h0, done}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_kind = 3'd0; req_value = 16'h0;
        req_alu = 13'h0; instr_ready = 1'b1; base_we = 1'b0; base_addr = 13'h0;
        exp_addr = 13'd0; last_code = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_instr", {16'h0, instr}, 32'd0);
        chk("rst_instr_addr", {19'h0, instr_addr}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_err_code", {30'h0, err_code}, 32'd0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic literal with one-cycle latency.
        send(3'd0, 16'h1234, 13'h0, 1'b1);
        chk("lit_valid", {31'h0, instr_valid}, 32'd1);
        chk("lit_word", {16'h0, instr}, 32'h9234);
        tick(); tick();

        // Long literal: expansion or rejection depending on build.
        send(3'd0, 16'hFFFE, 13'h0, 1'b1);
`ifdef J1_ENCODER_LONGLIT_EN
        chk("long1_req_ready", {31'h0, req_ready}, 32'd0);
        chk("long1_word", {16'h0, instr}, 32'h8001);
`else
        chk("longlit_err", {31'h0, err}, 32'd1);
        chk("longlit_no_word", {31'h0, instr_valid}, 32'd0);
`endif
        tick(); tick(); tick();

        // CALL held under backpressure.
        instr_ready = 1'b0;
        send(3'd3, 16'h0100, 13'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_instr", {16'h0, instr}, 32'h4100);
            chk("hold_valid", {31'h0, instr_valid}, 32'd1);
            chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick(); tick();

        // Rejections.
        send(3'd1, 16'h2000, 13'h0, 1'b1);
        chk("range_err", {31'h0, err}, 32'd1);
        chk("range_code", {30'h0, err_code}, 32'd1);
        chk("range_no_word", {31'h0, instr_valid}, 32'd0);
        tick();
        chk("err_pulse_end", {31'h0, err}, 32'd0);
        chk("err_code_hold", {30'h0, err_code}, 32'd1);
        send(3'd6, 16'h0000, 13'h0, 1'b1);
        tick();
        send(3'd4, 16'h0000, 13'h0010, 1'b1);
        tick(); tick();

        // Back-to-back words with no bubble.
        send(3'd2, 16'h0123, 13'h0, 1'b1);
        send(3'd4, 16'h0000, 13'h0A0C, 1'b1);
        chk("b2b_valid", {31'h0, instr_valid}, 32'd1);
        send(3'd0, 16'h7FFF, 13'h0, 1'b1);
        chk("b2b_valid2", {31'h0, instr_valid}, 32'd1);
        tick(); tick();

        // Base address load and wrap at 8191.
        base_we = 1'b1; base_addr = 13'd8191;
        tick();
        base_we = 1'b0;
        exp_addr = 13'd8191;
        send(3'd4, 16'h0000, 13'h0001, 1'b1);
        send(3'd4, 16'h0000, 13'h0002, 1'b1);
        tick(); tick();
        instr_ready = 1'b0;
        send(3'd4, 16'h0000, 13'h0003, 1'b1);
        base_we = 1'b1; base_addr = 13'd100;
        tick();
        base_we = 1'b0; instr_ready = 1'b1;
        tick();
        send(3'd4, 16'h0000, 13'h0004, 1'b1);
        tick(); tick();

        // Reset while a word (second half of a long literal when enabled) is pending.
        instr_ready = 1'b0;
`ifdef J1_ENCODER_LONGLIT_EN
        send(3'd0, 16'h8000, 13'h0, 1'b0);
        chk("pre_rst_req_ready", {31'h0, req_ready}, 32'd0);
`else
        send(3'd3, 16'h0050, 13'h0, 1'b0);
`endif
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, instr_valid}, 32'd0);
        chk("midrst_addr", {19'h0, instr_addr}, 32'd0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'd0);
        tick(); tick();
        reset = 1'b0; instr_ready = 1'b1;
        exp_addr = 13'd0; last_code = 2'd0;
        tick(); tick(); tick();
        chk("postrst_valid", {31'h0, instr_valid}, 32'd0);
        send(3'd0, 16'h0005, 13'h0, 1'b1);
        tick(); tick();

        chk("word_queue_empty", exp_q.size(), 32'd0);
        chk("err_queue_empty", err_q.size(), 32'd0);
        chk("err_code_final", {30'h0, err_code}, {30'h0, last_code});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
